// File: rtl/alu_seq_unit.sv
// alu_seq_unit: RV32 execute-stage ALU with a valid/ready result handshake.
// It decodes the operation class and {funct7, funct3} internally. Add, sub,
// and, or and slt complete in one cycle. Multiply runs as a radix-2 shift-add
// over XLEN cycles.
// Optional feature macro: ALU_DIV_EN adds a restoring divider for div/rem.
// When it is not defined, those two codes decode as slt and or.
module alu_seq_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [9:0]      func_code,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2, S_DIV = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
`endif

    typedef enum logic [2:0] {
        K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_MUL, K_DIV, K_REM
    } kind_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Iteration datapath, shared by the multiplier and the divider:
    //   mul: acc = partial product, opa = shifted multiplicand, opb = multiplier
    //   div: acc = partial remainder, opa = |divisor|, opb = dividend/quotient
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;

    logic [6:0]        f7;
    logic [2:0]        f3;
    kind_t             kind;
    logic              accept;
    logic [XLEN-1:0]   quick_val;
    logic [XLEN-1:0]   mul_acc_step;
    logic              last_iter;
    logic              wr_res;

`ifdef ALU_DIV_EN
    logic              is_rem_q, is_rem_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   rem_step, quot_step;
    logic [XLEN-1:0]   quot_fix, rem_fix;
`endif

    assign f7        = func_code[9:3];
    assign f3        = func_code[2:0];
    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt_q == LAST_ITER);

    // Operation decode; earlier entries win.
    always_comb begin
        kind = K_AND;
        if (!alu_op[1])
            kind = alu_op[0] ? K_SUB : K_ADD;
        else if (f7 == 7'b0000001 && f3 == 3'b000)
            kind = K_MUL;
`ifdef ALU_DIV_EN
        else if (f7 == 7'b0000001 && f3 == 3'b100)
            kind = K_DIV;
        else if (f7 == 7'b0000001 && f3 == 3'b110)
            kind = K_REM;
`endif
        else if (!f7[5] && f3 == 3'b000)
            kind = K_ADD;
        else if (f7[5] && f3 == 3'b000)
            kind = K_SUB;
        else if (!f7[5] && f3 == 3'b111)
            kind = K_AND;
        else if (!f7[5] && f3 == 3'b110)
            kind = K_OR;
        else if (f3 == 3'b100)
            kind = K_SLT;
        else
            kind = K_AND;
    end

    // Single-cycle results, computed straight from the live operands.
    always_comb begin
        quick_val = op_a & op_b;
        case (kind)
            K_ADD:   quick_val = op_a + op_b;
            K_SUB:   quick_val = op_a - op_b;
            K_OR:    quick_val = op_a | op_b;
            K_SLT:   quick_val = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: quick_val = op_a & op_b;
        endcase
    end

    // One shift-add multiply step.
    assign mul_acc_step = opb_q[0] ? (acc_q + opa_q) : acc_q;

`ifdef ALU_DIV_EN
    // Magnitudes taken at acceptance; signs are restored on the last step.
    assign a_abs = op_a[XLEN-1] ? (~op_a + 1'b1) : op_a;
    assign b_abs = op_b[XLEN-1] ? (~op_b + 1'b1) : op_b;

    // One restoring-division step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits (borrow bit clear).
    always_comb begin
        div_shift = {acc_q, opb_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opa_q};
        rem_step  = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        quot_step = {opb_q[XLEN-2:0], ~div_diff[XLEN]};
        quot_fix  = neg_quot_q ? (~quot_step + 1'b1) : quot_step;
        rem_fix   = neg_rem_q  ? (~rem_step + 1'b1)  : rem_step;
    end
`endif

    // Next-state and datapath update: iterate, retire, then accept.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        wr_res   = 1'b0;
`ifdef ALU_DIV_EN
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif

        case (state_q)
            S_MUL: begin
                acc_d = mul_acc_step;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d  = S_DONE;
                    result_d = mul_acc_step;
                    wr_res   = 1'b1;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                acc_d = rem_step;
                opb_d = quot_step;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d  = S_DONE;
                    result_d = is_rem_q ? rem_fix : quot_fix;
                    wr_res   = 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (out_ready && !in_valid)
                    state_d = S_IDLE;
            end
            default: ;
        endcase

        // Acceptance only happens in IDLE or DONE, so it overrides the above.
        if (accept) begin
            cnt_d = '0;
            case (kind)
                K_MUL: begin
                    state_d = S_MUL;
                    acc_d   = '0;
                    opa_d   = op_a;
                    opb_d   = op_b;
                end
`ifdef ALU_DIV_EN
                K_DIV, K_REM: begin
                    if (op_b == '0) begin
                        // A zero divisor needs no iterations; answer at once.
                        state_d  = S_DONE;
                        result_d = (kind == K_REM) ? op_a : '1;
                        wr_res   = 1'b1;
                    end else begin
                        state_d    = S_DIV;
                        acc_d      = '0;
                        opa_d      = b_abs;
                        opb_d      = a_abs;
                        is_rem_d   = (kind == K_REM);
                        neg_quot_d = op_a[XLEN-1] ^ op_b[XLEN-1];
                        neg_rem_d  = op_a[XLEN-1];
                    end
                end
`endif
                default: begin
                    state_d  = S_DONE;
                    result_d = quick_val;
                    wr_res   = 1'b1;
                end
            endcase
        end

        // zero follows the result only when a new result is written, so it
        // stays 0 out of reset even though result is 0.
        if (wr_res)
            zero_d = (result_d == '0);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
`ifdef ALU_DIV_EN
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
`ifdef ALU_DIV_EN
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign out_valid = (state_q == S_DONE);
`ifdef ALU_DIV_EN
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy      = (state_q == S_MUL);
`endif
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Testbench for alu_seq_unit (XLEN = 32). Checks results against a
// behavioural model built from plain arithmetic. Honours ALU_DIV_EN the same
// way the design does.
module tb_alu_seq_unit;

    localparam int XLEN = 32;

    localparam logic [9:0] FC_MUL = 10'b0000001_000;
    localparam logic [9:0] FC_DIV = 10'b0000001_100;
    localparam logic [9:0] FC_REM = 10'b0000001_110;
    localparam logic [9:0] FC_ADD = 10'b0000000_000;
    localparam logic [9:0] FC_SUB = 10'b0100000_000;
    localparam logic [9:0] FC_AND = 10'b0000000_111;
    localparam logic [9:0] FC_OR  = 10'b0000000_110;
    localparam logic [9:0] FC_SLT = 10'b0000000_100;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [9:0]      func_code;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func_code (func_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit want_rem);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
        sa = $signed(a);
        sb = $signed(b);
        q = sa / sb;
        r = sa % sb;
        return want_rem ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [9:0] fc,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = fc[9:3];
        f3 = fc[2:0];
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (fc == FC_MUL) return a * b;
`ifdef ALU_DIV_EN
        if (fc == FC_DIV) return ref_div(a, b, 1'b0);
        if (fc == FC_REM) return ref_div(a, b, 1'b1);
`endif
        if (!f7[5] && f3 == 3'd0) return a + b;
        if (f7[5] && f3 == 3'd0) return a - b;
        if (!f7[5] && f3 == 3'd7) return a & b;
        if (!f7[5] && f3 == 3'd6) return a | b;
        if (f3 == 3'd4) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return a & b;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [9:0] fc, input logic [31:0] b);
        if (!op[1]) return 1;
        if (fc == FC_MUL) return XLEN + 1;
`ifdef ALU_DIV_EN
        if ((fc == FC_DIV || fc == FC_REM) && b != 32'd0) return XLEN + 1;
`endif
        return 1;
    endfunction

    // ---------------- drivers ----------------
    task automatic settle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Issue one request and wait for its result. Inputs are scrambled right
    // after acceptance, so the result has to come from the captured operands.
    task automatic run_op(input logic [1:0] op, input logic [9:0] fc,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z,
                          output int lat, output int busy_cnt);
        int guard;
        @(negedge clk);
        in_valid  = 1'b1;
        alu_op    = op;
        func_code = fc;
        op_a      = a;
        op_b      = b;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        alu_op    = 2'($urandom);
        func_code = 10'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        res = result;
        z   = zero;
        $display("[TB] op=%b fc=%b a=%h b=%h -> result=%h zero=%0d lat=%0d", op, fc, a, b, res, z, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 2'b00;
        func_code = 10'd0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        tests_run++; if (result !== 32'd0) begin tests_failed++; $display("FAIL reset_result got=%h want=0", result); end
        tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("FAIL reset_zero got=%b want=0", zero); end
    endtask

    task automatic test_directed();
        logic [31:0] r;
        logic z;
        int lat;
        int bc;
        run_op(2'b00, 10'h3FF, 32'd5, 32'd7, r, z, lat, bc);
        tests_run++; if (r !== 32'd12) begin tests_failed++; $display("FAIL add_result got=%h want=0000000c", r); end
        tests_run++; if (z !== 1'b0) begin tests_failed++; $display("FAIL add_zero got=%b want=0", z); end
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL add_latency got=%0d want=1", lat); end

        run_op(2'b01, 10'h000, 32'd9, 32'd9, r, z, lat, bc);
        tests_run++; if (r !== 32'd0) begin tests_failed++; $display("FAIL sub_result got=%h want=0", r); end
        tests_run++; if (z !== 1'b1) begin tests_failed++; $display("FAIL sub_zero got=%b want=1", z); end

        run_op(2'b10, FC_MUL, 32'hFFFF_FFFF, 32'd3, r, z, lat, bc);
        tests_run++; if (r !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL mul_result got=%h want=fffffffd", r); end
        tests_run++; if (lat != XLEN + 1) begin tests_failed++; $display("FAIL mul_latency got=%0d want=%0d", lat, XLEN + 1); end
        tests_run++; if (bc != XLEN) begin tests_failed++; $display("FAIL mul_busy_cycles got=%0d want=%0d", bc, XLEN); end

        run_op(2'b10, FC_SLT, 32'hFFFF_FFFE, 32'd1, r, z, lat, bc);
        tests_run++; if (r !== 32'd1) begin tests_failed++; $display("FAIL slt_neg_lt_pos got=%h want=1", r); end
        run_op(2'b10, FC_SLT, 32'd1, 32'hFFFF_FFFE, r, z, lat, bc);
        tests_run++; if (r !== 32'd0) begin tests_failed++; $display("FAIL slt_pos_lt_neg got=%h want=0", r); end
        tests_run++; if (z !== 1'b1) begin tests_failed++; $display("FAIL slt_zero got=%b want=1", z); end
    endtask

    task automatic test_div_codes();
        logic [31:0] r;
        logic z;
        int lat;
        int bc;
`ifdef ALU_DIV_EN
        run_op(2'b10, FC_DIV, 32'hFFFF_FFF9, 32'd2, r, z, lat, bc);
        tests_run++; if (r !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_neg7_2 got=%h want=fffffffd", r); end
        tests_run++; if (lat != XLEN + 1) begin tests_failed++; $display("FAIL div_latency got=%0d want=%0d", lat, XLEN + 1); end
        run_op(2'b10, FC_REM, 32'hFFFF_FFF9, 32'd2, r, z, lat, bc);
        tests_run++; if (r !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rem_neg7_2 got=%h want=ffffffff", r); end
        run_op(2'b10, FC_DIV, 32'd9, 32'd0, r, z, lat, bc);
        tests_run++; if (r !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_by_zero got=%h want=ffffffff", r); end
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL div_by_zero_latency got=%0d want=1", lat); end
        run_op(2'b10, FC_REM, 32'd9, 32'd0, r, z, lat, bc);
        tests_run++; if (r !== 32'd9) begin tests_failed++; $display("FAIL rem_by_zero got=%h want=9", r); end
        run_op(2'b10, FC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, z, lat, bc);
        tests_run++; if (r !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_overflow got=%h want=80000000", r); end
        run_op(2'b10, FC_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, z, lat, bc);
        tests_run++; if (r !== 32'd0) begin tests_failed++; $display("FAIL rem_overflow got=%h want=0", r); end
`else
        run_op(2'b10, FC_DIV, 32'hFFFF_FFF9, 32'd2, r, z, lat, bc);
        tests_run++; if (r !== 32'd1) begin tests_failed++; $display("FAIL divcode_as_slt got=%h want=1", r); end
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL divcode_latency got=%0d want=1", lat); end
        run_op(2'b10, FC_REM, 32'h0000_00F0, 32'h0000_000F, r, z, lat, bc);
        tests_run++; if (r !== 32'h0000_00FF) begin tests_failed++; $display("FAIL remcode_as_or got=%h want=000000ff", r); end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] r0;
        logic z0;
        int guard;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        d = $urandom;
        settle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 2'b10;
        func_code = FC_MUL;
        op_a      = a;
        op_b      = b;
        @(posedge clk);
        @(negedge clk);
        // A pending add that must be ignored until the mul result retires.
        alu_op = 2'b00;
        op_a   = c;
        op_b   = d;
        guard = 0;
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        r0 = result;
        z0 = zero;
        $display("[TB] stall mul a=%h b=%h -> result=%h", a, b, r0);
        tests_run++; if (r0 !== a * b) begin tests_failed++; $display("FAIL stall_mul_result got=%h want=%h", r0, a * b); end
        tests_run++; if (z0 !== (a * b == 32'd0)) begin tests_failed++; $display("FAIL stall_mul_zero got=%b", z0); end
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (out_valid !== 1'b1 || result !== r0 || zero !== z0 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold cycle=%0d got valid=%b result=%h zero=%b in_ready=%b want 1/%h/%b/0",
                         i, out_valid, result, zero, in_ready, r0, z0);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        $display("[TB] stall add a=%h b=%h -> result=%h", c, d, result);
        tests_run++; if (out_valid !== 1'b1 || result !== c + d) begin
            tests_failed++;
            $display("FAIL stall_then_add got valid=%b result=%h want 1/%h", out_valid, result, c + d);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        logic [1:0]  ops[N];
        logic [9:0]  fcs[N];
        logic [31:0] as[N];
        logic [31:0] bs[N];
        logic [31:0] exp_r;
        for (int i = 0; i < N; i++) begin
            do begin
                ops[i] = 2'($urandom);
                fcs[i] = 10'($urandom);
                as[i]  = $urandom;
                bs[i]  = $urandom;
            end while (ref_latency(ops[i], fcs[i], bs[i]) != 1);
        end
        settle();
        in_valid  = 1'b1;
        alu_op    = ops[0];
        func_code = fcs[0];
        op_a      = as[0];
        op_b      = bs[0];
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_r = ref_result(ops[i], fcs[i], as[i], bs[i]);
            $display("[TB] b2b op=%b fc=%b a=%h b=%h -> result=%h", ops[i], fcs[i], as[i], bs[i], result);
            tests_run++; if (out_valid !== 1'b1 || result !== exp_r) begin
                tests_failed++;
                $display("FAIL b2b_%0d got valid=%b result=%h want 1/%h", i, out_valid, result, exp_r);
            end
            if (i < N - 1) begin
                alu_op    = ops[i+1];
                func_code = fcs[i+1];
                op_a      = as[i+1];
                op_b      = bs[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        settle();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [9:0]  fc_tab[9];
        logic [1:0]  op;
        logic [9:0]  fc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] exp_r;
        logic z;
        int lat;
        int bc;
        fc_tab = '{FC_MUL, FC_DIV, FC_REM, FC_ADD, FC_SUB, FC_AND, FC_OR, FC_SLT, 10'd0};
        for (int i = 0; i < 70; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
            fc = fc_tab[$urandom_range(0, 8)];
            if (fc == 10'd0) fc = 10'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_op(op, fc, a, b, r, z, lat, bc);
            exp_r = ref_result(op, fc, a, b);
            tests_run++; if (r !== exp_r || z !== (exp_r == 32'd0) || lat != ref_latency(op, fc, b)) begin
                tests_failed++;
                $display("FAIL random_%0d op=%b fc=%b a=%h b=%h got %h/%b/lat%0d want %h/%b/lat%0d",
                         i, op, fc, a, b, r, z, lat, exp_r, exp_r == 32'd0, ref_latency(op, fc, b));
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        settle();
        in_valid  = 1'b1;
        alu_op    = 2'b10;
        func_code = FC_MUL;
        op_a      = 32'h1234_5678;
        op_b      = 32'h0000_0101;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        $display("[TB] reset during mul at iteration 10");
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        tests_run++; if (result !== 32'd0) begin tests_failed++; $display("FAIL rstmid_result got=%h want=0", result); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL rstmid_ghost_result got=%0d cycles want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_codes();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Sequencing ALU for the RV32 execute stage, configurable in width. It decodes the 2-bit ALU operation class and the {funct7, funct3} function code itself, then runs the operation. Add, sub, and, or and signed less-than finish in one cycle. Multiply, and the optional divide/remainder, run as iterative multi-cycle operations. Results are returned through a valid/ready handshake, so the pipeline can stall on long operations.

## Interface
Parameters:
- XLEN, 32, operand and result width; legal range 4..64.
- CNT_W, $clog2(XLEN), iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request this cycle.
- alu_op  in  2  operation class: 00 add, 01 sub, 1x decode func_code.
- func_code  in  10  {funct7[6:0], funct3[2:0]}.
- op_a  in  XLEN  first operand (rs1).
- op_b  in  XLEN  second operand (rs2/imm).
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0.
- busy  out  1  a multi-cycle operation is in progress.

## Operation
- Decode when alu_op = 1x. First match wins:
  - 0000001_000: mul.
  - 0000001_100: div (only with ALU_DIV_EN).
  - 0000001_110: rem (only with ALU_DIV_EN).
  - x0xxxxx_000: add.
  - x1xxxxx_000: sub.
  - x0xxxxx_111: and.
  - x0xxxxx_110: or.
  - xxxxxxx_100: slt, signed; result = {XLEN-1 zeros, op_a < op_b}.
  - anything else: and.
- alu_op = 00 gives add; 01 gives sub. Both ignore func_code.
- Arithmetic wraps modulo 2^XLEN; there is no overflow flag.
- Mul is radix-2 shift-add on the low XLEN bits and returns the low XLEN bits of the product. This is correct for signed and unsigned operands.
- Div/rem are restoring division on absolute values, with the sign corrected at the end:
  - quotient rounds toward zero;
  - remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = op_a. Detected at acceptance.
- Overflow (most-negative / -1): quotient = op_a, remainder = 0.
- State machine:
  - IDLE -> DONE: single-cycle op or div-by-zero accepted.
  - IDLE -> MUL: mul accepted.
  - IDLE -> DIV: div/rem accepted.
  - MUL/DIV -> DONE: after XLEN iterations.
  - DONE -> IDLE: out_ready with no new request.
  - DONE -> new target: out_ready with in_valid.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- out_valid = (state==DONE). busy = (state==MUL || state==DIV).
- Request signals are ignored while in_ready = 0. Operands are captured at acceptance; the inputs may then change freely.

## Timing
- Acceptance edge T is the rising edge with in_valid && in_ready.
- Single-cycle ops and div-by-zero: out_valid = 1 and result valid after edge T (latency 1).
- Mul/div/rem: one iteration per edge T+1..T+XLEN; out_valid = 1 after edge T+XLEN (latency XLEN+1). busy = 1 from after edge T until edge T+XLEN.
- result and zero stay stable while out_valid && !out_ready.
- Back-to-back: in DONE with out_ready && in_valid, the old result retires and the new request is accepted on the same edge, with no bubble.
- Reset values: state IDLE, result 0, zero 0, out_valid 0, busy 0, in_ready 1 (in the cycle after the reset edge). The counter and internal registers clear to 0.
- Reset mid-operation abandons the operation with no output. reset has priority over the handshake on the same edge.

## Configuration
- ALU_DIV_EN defined:
  - the DIV state and restoring divider are compiled in;
  - 0000001_100 selects div and 0000001_110 selects rem.
- ALU_DIV_EN undefined:
  - no divider logic and no DIV state;
  - those two codes fall through to the normal table (slt and or respectively).

## Test plan
- XLEN=32, alu_op=00, op_a=5, op_b=7 -> result 12, zero 0, out_valid after 1 cycle. Repeat with alu_op=01, op_a=op_b=9 -> result 0, zero 1.
- alu_op=10, func_code=0000001_000, op_a=0xFFFFFFFF, op_b=3 -> busy for 32 cycles, then result 0xFFFFFFFD, out_valid at T+32.
- alu_op=10, func_code=0000000_100, op_a=0xFFFFFFFE (-2), op_b=1 -> result 1. Then op_a=1, op_b=-2 -> result 0.
- Mul completes with out_ready=0 for 5 cycles -> result, out_valid and zero stay constant; in_ready=0. Then out_ready=1 with a pending add -> accepted that same edge, and the add result appears next cycle.
- reset=1 at iteration 10 of a mul -> next cycle: state IDLE, out_valid 0, busy 0, result 0, in_ready 1; the abandoned product never appears.
- With ALU_DIV_EN:
  - div -7/2 -> 0xFFFFFFFD (-3);
  - rem -7/2 -> 0xFFFFFFFF (-1);
  - div 9/0 -> 0xFFFFFFFF at latency 1;
  - div 0x80000000/-1 -> 0x80000000.
  Without ALU_DIV_EN, the same div code gives the slt result.
